// File: rtl/kim_counter_pkg.sv
// Shared types and defaults for the counter sequencer.
// Holds the FSM state encoding and the default count width.
package kim_counter_pkg;

  localparam int DEF_CNT_DATA_WIDTH = 7;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ARM,
    RUN,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/kim_cmd_fifo.sv
// Synchronous command FIFO with level and full/empty flags.
// Ports: clk, rst, push/push_data, pop/pop_data, level, full, empty.
module kim_cmd_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A pop in the same cycle frees a slot, so push-when-full is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + LW'(1);
      end else if (do_pop && !do_push) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/kim_counter_seq.sv
// Sequencer that queues count commands, launches the counter and
// reports done/timeout_err with the target value in done_val.
module kim_counter_seq
  import kim_counter_pkg::*;
#(
  parameter int CNT_DATA_WIDTH = DEF_CNT_DATA_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int TO_MARGIN      = 16,
  parameter int LW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  input  logic [CNT_DATA_WIDTH-1:0] cmd_val,
  output logic                      cmd_ready,
  output logic                      start,
  output logic [CNT_DATA_WIDTH-1:0] cnt_val,
  input  logic [CNT_DATA_WIDTH-1:0] cnt,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_DATA_WIDTH-1:0] done_val,
  output logic                      timeout_err,
  output logic [LW-1:0]             fifo_level
);

  localparam int W  = CNT_DATA_WIDTH;
  // Wide enough that target + TO_MARGIN never wraps.
  localparam int TW = W + $clog2(TO_MARGIN) + 1;

  state_t        state;
  state_t        state_n;
  logic [W-1:0]  target;
  logic [W-1:0]  target_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic [TW-1:0] timer_inc;
  logic [TW-1:0] limit;
  logic          pop;
  logic [W-1:0]  head;
  logic          full;
  logic          empty;

  kim_cmd_fifo #(
    .W     (W),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid && cmd_ready),
    .push_data (cmd_val),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level),
    .full      (full),
    .empty     (empty)
  );

  assign cmd_ready = !full;
  assign busy      = (state != IDLE) || !empty;

  assign timer_inc = timer + TW'(1);
  assign limit     = TW'(target) + TW'(TO_MARGIN);

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    pop      = 1'b0;
    target_n = target;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          target_n = head;
          state_n  = (head == '0) ? DONE : LAUNCH;
        end
      end
      LAUNCH: begin
        timer_n = '0;
        state_n = ARM;
      end
      ARM: begin
        state_n = RUN;
      end
      RUN: begin
        // timer_inc counts RUN cycles including this one.
        timer_n = timer_inc;
        if (cnt == target) begin
          state_n = DONE;
        end else if (timer_inc == limit) begin
          state_n = ERR;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      ERR: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      target      <= '0;
      timer       <= '0;
      start       <= 1'b0;
      cnt_val     <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      done_val    <= '0;
    end else begin
      state       <= state_n;
      target      <= target_n;
      timer       <= timer_n;
      // Output registers mirror the state being entered.
      start       <= (state_n == LAUNCH);
      cnt_val     <= (state_n == LAUNCH) ? target_n : '0;
      done        <= (state_n == DONE);
      timeout_err <= (state_n == ERR);
      if (state_n == DONE || state_n == ERR) begin
        done_val <= target_n;
      end
    end
  end

endmodule

// File: tb/tb_kim_counter_seq.sv
// Bench for kim_counter_seq with a behavioural counter partner.
// Scoreboard queues hold expected starts and completions.
module tb_kim_counter_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_val = '0;
  logic       cmd_ready;
  logic       start;
  logic [6:0] cnt_val;
  logic [6:0] cnt;
  logic       busy;
  logic       done;
  logic [6:0] done_val;
  logic       timeout_err;
  logic [2:0] fifo_level;

  logic       stall = 1'b0;
  logic [6:0] mcnt;
  logic [6:0] mval;

  typedef struct packed {
    logic       err;
    logic [6:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] start_q[$];
  bit         exp_err = 1'b0;

  int checks = 0;
  int failures = 0;
  int start_count = 0;
  int done_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  kim_counter_seq dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_val     (cmd_val),
    .cmd_ready   (cmd_ready),
    .start       (start),
    .cnt_val     (cnt_val),
    .cnt         (cnt),
    .busy        (busy),
    .done        (done),
    .done_val    (done_val),
    .timeout_err (timeout_err),
    .fifo_level  (fifo_level)
  );

  // Counter partner: loads on start, counts 0 up to cnt_val, holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= '0;
      mval <= '0;
    end else if (start) begin
      mcnt <= '0;
      mval <= cnt_val;
    end else if (mcnt < mval) begin
      mcnt <= mcnt + 7'd1;
    end
  end

  assign cnt = stall ? 7'd0 : mcnt;

  always @(negedge clk) begin
    if (!rst) begin
      if (start) begin
        start_count++;
        checks++;
        if (start_q.size() == 0) begin
          failures++;
          $display("FAIL sb_start unexpected cnt_val=%0d", cnt_val);
        end else begin
          logic [6:0] es;
          es = start_q.pop_front();
          if (cnt_val !== es) begin
            failures++;
            $display("FAIL sb_start cnt_val=%0d exp=%0d",
                     cnt_val, es);
          end
        end
      end
      if (done || timeout_err) begin
        if (done) done_count++;
        if (timeout_err) err_count++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_done unexpected done=%0b err=%0b val=%0d",
                   done, timeout_err, done_val);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({timeout_err, done, done_val} !==
              {e.err, !e.err, e.val}) begin
            failures++;
            $display("FAIL sb_done got err=%0b done=%0b val=%0d exp err=%0b val=%0d",
                     timeout_err, done, done_val, e.err, e.val);
          end
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the transfer.
  task automatic push(input logic [6:0] v);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_val   = v;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    if (ok) begin
      exp_q.push_back({exp_err, v});
      if (v != 0) start_q.push_back(v);
    end
    #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL push_timeout val=%0d", v);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || exp_q.size() != 0 || start_q.size() != 0) begin
      failures++;
      $display("FAIL wait_idle busy=%0b pend_done=%0d pend_start=%0d",
               busy, exp_q.size(), start_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (start) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_start no start pulse");
    end
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if ({start, done, timeout_err, busy, cmd_ready} !== 5'b00001 ||
        fifo_level !== 3'd0 || cnt_val !== 7'd0 ||
        done_val !== 7'd0) begin
      failures++;
      $display("FAIL %s st=%0b dn=%0b er=%0b bz=%0b rdy=%0b lvl=%0d cv=%0d dv=%0d exp rdy=1 rest 0",
               name, start, done, timeout_err, busy, cmd_ready,
               fifo_level, cnt_val, done_val);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    int n;
    bit seen;
    push(7'd100);
    @(negedge clk);
    checks++;
    if (start !== 1'b0 || fifo_level !== 3'd1) begin
      failures++;
      $display("FAIL single_queued start=%0b lvl=%0d exp 0/1",
               start, fifo_level);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || cnt_val !== 7'd100) begin
      failures++;
      $display("FAIL single_launch start=%0b cnt_val=%0d exp 1/100",
               start, cnt_val);
    end
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || n != 102) begin
      failures++;
      $display("FAIL single_latency cycles=%0d exp=102", n);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy_done busy=%0b exp=1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL single_after busy=%0b done=%0b exp 0/0",
               busy, done);
    end
    wait_idle(10);
  endtask

  task automatic test_back_to_back;
    int d0;
    int e0;
    d0 = done_count;
    e0 = err_count;
    push(7'd3);
    push(7'd5);
    push(7'd7);
    wait_idle(100);
    checks++;
    if (done_count - d0 != 3 || err_count != e0) begin
      failures++;
      $display("FAIL b2b_counts done=%0d err=%0d exp 3/0",
               done_count - d0, err_count - e0);
    end
  endtask

  task automatic test_zero;
    int s0;
    s0 = start_count;
    push(7'd0);
    wait_idle(20);
    checks++;
    if (start_count != s0) begin
      failures++;
      $display("FAIL zero_nostart starts=%0d exp=0",
               start_count - s0);
    end
  endtask

  task automatic test_timeout;
    int n;
    bit seen;
    bit ok;
    stall = 1'b1;
    exp_err = 1'b1;
    push(7'd10);
    wait_start(ok);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (timeout_err || done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || n != 28 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_latency cycles=%0d err=%0b exp 28/1",
               n, timeout_err);
    end
    wait_idle(10);
    stall = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic test_fifo_full;
    bit ok;
    push(7'd30);
    wait_start(ok);
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) begin
      push(7'(i));
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
      failures++;
      $display("FAIL full_flag rdy=%0b lvl=%0d exp 0/4",
               cmd_ready, fifo_level);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_val   = 7'd9;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd4) begin
      failures++;
      $display("FAIL full_ignore lvl=%0d exp=4", fifo_level);
    end
    wait_idle(200);
    checks++;
    if (fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL full_drain lvl=%0d exp=0", fifo_level);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    push(7'd50);
    wait_start(ok);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async_reset");
    exp_q.delete();
    start_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(7'd2);
    wait_idle(30);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_timeout();
    test_fifo_full();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
